// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded operands/control coming in from ID, registered EX view going out.
// The slave modport is the pipeline register; the master modport is whoever drives ID.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
);
  logic [XLEN-1:0]   IF_ID_pc;
  logic [4:0]        IF_ID_rs1;
  logic [4:0]        IF_ID_rs2;
  logic [4:0]        IF_ID_rd;
  logic              IF_ID_use_rs1;
  logic              IF_ID_use_rs2;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [CTRL_W-1:0] ctrl_in;
  logic              IF_ID_valid;
  logic              flush;
  logic              mem_stall;

  logic [XLEN-1:0]   ID_EX_pc;
  logic [4:0]        ID_EX_rs1;
  logic [4:0]        ID_EX_rs2;
  logic [4:0]        ID_EX_rd;
  logic [XLEN-1:0]   ID_EX_rs1_data;
  logic [XLEN-1:0]   ID_EX_rs2_data;
  logic [XLEN-1:0]   ID_EX_imm;
  logic [CTRL_W-1:0] ID_EX_ctrl;
  logic              ID_EX_valid;
  logic              load_use_stall;

  modport master (
    output IF_ID_pc, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_use_rs1, IF_ID_use_rs2,
           rs1_data, rs2_data, imm, ctrl_in, IF_ID_valid, flush, mem_stall,
    input  ID_EX_pc, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_rs1_data, ID_EX_rs2_data,
           ID_EX_imm, ID_EX_ctrl, ID_EX_valid, load_use_stall
  );

  modport slave (
    input  IF_ID_pc, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_use_rs1, IF_ID_use_rs2,
           rs1_data, rs2_data, imm, ctrl_in, IF_ID_valid, flush, mem_stall,
    output ID_EX_pc, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_rs1_data, ID_EX_rs2_data,
           ID_EX_imm, ID_EX_ctrl, ID_EX_valid, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and memory-stall hold.
// Optional bubble/hold performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic clk,
  input  logic rstn,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] hold_cnt
`endif
);
  localparam int MemReadBit = CTRL_W - 2;

  typedef enum logic [1:0] {
    ActLoad,
    ActBubble,
    ActHold
  } action_e;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rs1Data_q, rs1Data_d;
  logic [XLEN-1:0]   rs2Data_q, rs2Data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;

  logic    rs1Hit;
  logic    rs2Hit;
  logic    hz;
  action_e action;

  // The hazard looks at the load already sitting in EX against the sources of the ID instruction.
  always_comb begin
    rs1Hit = bus.IF_ID_use_rs1 && (bus.IF_ID_rs1 == rd_q);
    rs2Hit = bus.IF_ID_use_rs2 && (bus.IF_ID_rs2 == rd_q);
    hz     = valid_q && ctrl_q[MemReadBit] && (rd_q != 5'd0) &&
             bus.IF_ID_valid && (rs1Hit || rs2Hit);
    if (bus.mem_stall) begin
      action = ActHold;
    end else if (bus.flush || hz) begin
      action = ActBubble;
    end else begin
      action = ActLoad;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    rs1Data_d = rs1Data_q;
    rs2Data_d = rs2Data_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    case (action)
      ActLoad: begin
        pc_d      = bus.IF_ID_pc;
        rs1_d     = bus.IF_ID_rs1;
        rs2_d     = bus.IF_ID_rs2;
        rd_d      = bus.IF_ID_rd;
        rs1Data_d = bus.rs1_data;
        rs2Data_d = bus.rs2_data;
        imm_d     = bus.imm;
        ctrl_d    = bus.IF_ID_valid ? bus.ctrl_in : '0;
        valid_d   = bus.IF_ID_valid;
      end
      // Only ctrl/valid/rd matter for a bubble; the payload fields just follow the inputs.
      ActBubble: begin
        pc_d      = bus.IF_ID_pc;
        rs1_d     = bus.IF_ID_rs1;
        rs2_d     = bus.IF_ID_rs2;
        rd_d      = 5'd0;
        rs1Data_d = bus.rs1_data;
        rs2Data_d = bus.rs2_data;
        imm_d     = bus.imm;
        ctrl_d    = '0;
        valid_d   = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1Data_q <= '0;
      rs2Data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      rs1Data_q <= rs1Data_d;
      rs2Data_q <= rs2Data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.ID_EX_pc       = pc_q;
  assign bus.ID_EX_rs1      = rs1_q;
  assign bus.ID_EX_rs2      = rs2_q;
  assign bus.ID_EX_rd       = rd_q;
  assign bus.ID_EX_rs1_data = rs1Data_q;
  assign bus.ID_EX_rs2_data = rs2Data_q;
  assign bus.ID_EX_imm      = imm_q;
  assign bus.ID_EX_ctrl     = ctrl_q;
  assign bus.ID_EX_valid    = valid_q;
  // A flush or a memory freeze already stops the front end, so the stall is suppressed then.
  assign bus.load_use_stall = hz && !bus.flush && !bus.mem_stall;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubbleCnt_q, bubbleCnt_d;
  logic [31:0] holdCnt_q, holdCnt_d;

  always_comb begin
    bubbleCnt_d = bubbleCnt_q;
    holdCnt_d   = holdCnt_q;
    if (action == ActBubble) begin
      bubbleCnt_d = bubbleCnt_q + 32'd1;
    end
    if (action == ActHold) begin
      holdCnt_d = holdCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bubbleCnt_q <= '0;
      holdCnt_q   <= '0;
    end else begin
      bubbleCnt_q <= bubbleCnt_d;
      holdCnt_q   <= holdCnt_d;
    end
  end

  assign bubble_cnt = bubbleCnt_q;
  assign hold_cnt   = holdCnt_q;
`endif
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I pipeline, with integrated load-use hazard detection.
- Captures decoded operands and control from ID each cycle.
- Presents ID_EX_rs1/ID_EX_rs2/ID_EX_rd and the WB/MEM control bits to the EX-stage forwarding unit and the ALU.
- Inserts bubbles on a load-use hazard or a taken-branch flush, and holds on a global memory stall.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 8, packed control width: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]}, MSB first.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- IF_ID_pc  in  XLEN  PC of instruction in ID
- IF_ID_rs1  in  5  source register 1 index
- IF_ID_rs2  in  5  source register 2 index
- IF_ID_rd  in  5  destination register index
- IF_ID_use_rs1  in  1  instruction reads rs1
- IF_ID_use_rs2  in  1  instruction reads rs2
- rs1_data  in  XLEN  register file read port 1
- rs2_data  in  XLEN  register file read port 2
- imm  in  XLEN  sign-extended immediate
- ctrl_in  in  CTRL_W  decoded control
- IF_ID_valid  in  1  ID holds a real instruction
- flush  in  1  taken branch resolved in EX; kill the ID instruction
- mem_stall  in  1  global freeze from the data-memory port
- ID_EX_pc  out  XLEN  registered PC
- ID_EX_rs1  out  5  registered rs1 index; feeds the forwarding unit
- ID_EX_rs2  out  5  registered rs2 index; feeds the forwarding unit
- ID_EX_rd  out  5  registered rd
- ID_EX_rs1_data  out  XLEN  registered operand 1
- ID_EX_rs2_data  out  XLEN  registered operand 2
- ID_EX_imm  out  XLEN  registered immediate
- ID_EX_ctrl  out  CTRL_W  registered control
- ID_EX_valid  out  1  EX holds a real instruction
- load_use_stall  out  1  combinational; freeze PC and IF/ID this cycle

Behaviour:
- Reset: rstn low asynchronously clears every registered output to 0, including ctrl and valid, so EX holds a bubble.
- Reset release is synchronous-safe: the first capture happens on the first rising edge after rstn goes high.
- Hazard detect, combinational:
  - hz = ID_EX_valid & ID_EX_ctrl.MemRead & (ID_EX_rd!=0) & IF_ID_valid & ((IF_ID_use_rs1 & IF_ID_rs1==ID_EX_rd) | (IF_ID_use_rs2 & IF_ID_rs2==ID_EX_rd)).
  - load_use_stall = hz & ~flush & ~mem_stall.
- Per rising edge, first matching rule wins:
  1. mem_stall=1: HOLD. All registers unchanged, regardless of flush or hz; flush is re-presented by EX while frozen.
  2. flush=1: BUBBLE. ctrl<=0, valid<=0, rd<=0. Index, data, pc and imm fields may take don't-care values.
  3. hz=1: BUBBLE, as in rule 2. The instruction remains in IF/ID and is re-presented next cycle.
  4. Otherwise: LOAD all fields from inputs. valid<=IF_ID_valid; ctrl<=IF_ID_valid ? ctrl_in : 0.
- Latency: one cycle from ID inputs to ID_EX_* outputs.
- A load followed by a dependent instruction produces exactly one bubble; the second cycle sees the load in MEM and forwarding resolves it.
- A bubble always has RegWrite=0 and MemWrite=0, so downstream forwarding never matches on it.
- rd=0 never raises hz. A load to x0 creates no stall.
- Back-to-back dependent loads stall once per dependent pair.
- Reset asserted during a stall returns the block to the bubble state; no hold state survives reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two outputs:
  - bubble_cnt, 32-bit: increments on every rule-2 or rule-3 edge.
  - hold_cnt, 32-bit: increments on every rule-1 edge.
- Both counters wrap modulo 2^32 and reset to 0 on rstn low.
- When undefined, the outputs and counters are absent and the block is otherwise identical.

Test Plan:
- Reset: rstn=0 mid-cycle with registers loaded -> all outputs 0 immediately, before any clock edge; load_use_stall=0.
- Normal advance: IF_ID_pc=0x100, rs1=3, rs2=4, rd=5, ctrl=0x84, valid=1 -> next edge shows the same values on ID_EX_*, ID_EX_valid=1.
- Load-use: EX holds lw x7 (MemRead=1, rd=7); ID holds add reading rs1=7 -> load_use_stall=1.
  - Next edge: ID_EX_ctrl=0, ID_EX_valid=0.
  - Following edge: add loaded, stall=0.
  - Repeat with rd=0 -> no stall.
- Flush priority: flush=1 together with hz=1 -> bubble inserted, load_use_stall=0.
- mem_stall: mem_stall=1 for 3 cycles with flush=1 and changing inputs -> outputs frozen, load_use_stall=0; flush takes effect on the first edge after mem_stall drops.
- Perf (macro on): 2 load-use bubbles, 1 flush and 3 hold cycles -> bubble_cnt=3, hold_cnt=3.
